// File: rtl/uart_pkg.sv
// Shared frame constants, transmit FSM states and the parity helper for the UART path.
package uart_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a sticky overflow on refused writes.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    // Gating uses the registered flags, so a pop in the same cycle never frees room for a push.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
            if (push && full) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: FIFO-buffered bytes framed as start, 8 data LSB-first, parity, stop.
import uart_pkg::*;

module uart_tx_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       overflow,
    output logic       tx
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    tx_state_e              state;
    logic [DIV_W-1:0]       div_cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   par;
    logic [DATA_BITS-1:0]   head;
    logic                   bit_end;
    logic                   pop;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .pop      (pop),
        .wdata    (data_in),
        .rdata    (head),
        .full     (tx_full),
        .empty    (tx_empty),
        .overflow (overflow)
    );

    assign bit_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    // Pop from IDLE, or at the end of STOP to chain the next frame with no idle bit.
    assign pop     = ~tx_empty & ((state == IDLE) | ((state == STOP) & bit_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            // tx follows the current state, so it only moves on bit boundaries.
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                PARITY:  tx <= par;
                default: tx <= 1'b1;
            endcase

            if (state == IDLE || bit_end) div_cnt <= '0;
            else                          div_cnt <= div_cnt + DIV_W'(1);

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift   <= head;
                        par     <= calc_parity(head, 1'(PARITY_ODD));
                        state   <= START;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift <= head;
                            par   <= calc_parity(head, 1'(PARITY_ODD));
                            state <= START;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer checked against a frame-countdown reference model.
module tb_uart_tx_serializer;

    localparam int DIV   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx_full, tx_empty, tx_busy, overflow, tx;

    logic       wr_en_o = 1'b0;
    logic [7:0] data_in_o = 8'h00;
    logic       tx_full_o, tx_empty_o, tx_busy_o, overflow_o, tx_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
        .overflow(overflow), .tx(tx)
    );

    uart_tx_serializer #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .wr_en(wr_en_o), .data_in(data_in_o),
        .tx_full(tx_full_o), .tx_empty(tx_empty_o), .tx_busy(tx_busy_o),
        .overflow(overflow_o), .tx(tx_o)
    );

    // Line level at position p (0..10) of a frame carrying byte d.
    function automatic logic fbit(input logic [7:0] d, input int p, input logic odd);
        if (p == 0) return 1'b0;
        if (p <= 8) return d[p-1];
        if (p == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    // Reference: a byte queue plus a countdown of cycles left in the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] cur = 8'h00;
    int         remain = 0;
    logic       e_tx = 1'b1, e_busy = 1'b0, e_empty = 1'b1, e_full = 1'b0, e_ovf = 1'b0;

    always @(posedge clk) begin
        bit full_b;
        bit do_pop;
        if (rst) begin
            mq.delete();
            remain = 0;
            e_ovf  = 1'b0;
            e_tx   = 1'b1;
        end else begin
            e_tx   = (remain > 0) ? fbit(cur, (FRAME*DIV - remain) / DIV, 1'b0) : 1'b1;
            full_b = (mq.size() == DEPTH);
            do_pop = (mq.size() > 0) && (remain <= 1);
            if (wr_en && full_b) e_ovf = 1'b1;
            if (do_pop) begin
                cur    = mq.pop_front();
                remain = FRAME * DIV;
            end else if (remain > 0) begin
                remain = remain - 1;
            end
            if (wr_en && !full_b) mq.push_back(data_in);
        end
        e_busy  = (remain > 0);
        e_empty = (mq.size() == 0);
        e_full  = (mq.size() == DEPTH);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        tick();
        tick();
        checks++;
        if ({tx, tx_busy, tx_empty, tx_full, overflow} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_state: got %b exp 10100", {tx, tx_busy, tx_empty, tx_full, overflow});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({tx, tx_busy, tx_empty, tx_full, overflow} !== {e_tx, e_busy, e_empty, e_full, e_ovf}) begin
            errors++;
            $display("FAIL reset_model: got %b exp %b", {tx, tx_busy, tx_empty, tx_full, overflow},
                     {e_tx, e_busy, e_empty, e_full, e_ovf});
        end
    endtask

    task automatic test_single();
        logic a5 [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int busy_cnt = 0;
        wr_en = 1'b1;
        data_in = 8'hA5;
        tick();
        wr_en = 1'b0;
        checks++;
        if (tx_empty !== 1'b0) begin
            errors++;
            $display("FAIL single_empty_fall: got %b exp 0", tx_empty);
        end
        for (int j = 1; j <= 50; j++) begin
            tick();
            if (tx_busy) busy_cnt++;
            checks++;
            if ({tx, tx_busy, tx_empty, tx_full, overflow} !== {e_tx, e_busy, e_empty, e_full, e_ovf}) begin
                errors++;
                $display("FAIL single_model cyc %0d: got %b exp %b", j, {tx, tx_busy, tx_empty, tx_full, overflow},
                         {e_tx, e_busy, e_empty, e_full, e_ovf});
            end
            if (j == 1) begin
                checks++;
                if (tx !== 1'b1) begin
                    errors++;
                    $display("FAIL single_latency: tx %b one edge after write, exp 1", tx);
                end
            end else if (j <= 45) begin
                checks++;
                if (tx !== a5[(j-2)/DIV]) begin
                    errors++;
                    $display("FAIL single_a5_bit cyc %0d: got %b exp %b", j, tx, a5[(j-2)/DIV]);
                end
            end
        end
        checks++;
        if (busy_cnt != 11*DIV) begin
            errors++;
            $display("FAIL single_busy_len: got %0d exp %0d", busy_cnt, 11*DIV);
        end
    endtask

    task automatic test_odd_parity();
        logic f01 [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic f00 [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        wr_en_o = 1'b1;
        data_in_o = 8'h01;
        tick();
        wr_en_o = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (tx_o !== f01[i]) begin
                errors++;
                $display("FAIL odd_0x01 bit %0d: got %b exp %b", i, tx_o, f01[i]);
            end
            repeat (DIV) tick();
        end
        repeat (4) tick();
        wr_en_o = 1'b1;
        data_in_o = 8'h00;
        tick();
        wr_en_o = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (tx_o !== f00[i]) begin
                errors++;
                $display("FAIL odd_0x00 bit %0d: got %b exp %b", i, tx_o, f00[i]);
            end
            repeat (DIV) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        int busy_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1;
            data_in = bytes[k];
            tick();
            if (tx_busy) busy_cnt++;
        end
        wr_en = 1'b0;
        for (int j = 0; j < 150; j++) begin
            tick();
            if (tx_busy) busy_cnt++;
            checks++;
            if ({tx, tx_busy, tx_empty, tx_full, overflow} !== {e_tx, e_busy, e_empty, e_full, e_ovf}) begin
                errors++;
                $display("FAIL b2b_model cyc %0d: got %b exp %b", j, {tx, tx_busy, tx_empty, tx_full, overflow},
                         {e_tx, e_busy, e_empty, e_full, e_ovf});
            end
        end
        checks++;
        if (busy_cnt != 3*11*DIV) begin
            errors++;
            $display("FAIL b2b_busy_len: got %0d exp %0d", busy_cnt, 3*11*DIV);
        end
    endtask

    task automatic test_overflow();
        for (int j = 0; j < 18; j++) begin
            wr_en = 1'b1;
            data_in = 8'($urandom);
            tick();
            checks++;
            if ({tx, tx_busy, tx_empty, tx_full, overflow} !== {e_tx, e_busy, e_empty, e_full, e_ovf}) begin
                errors++;
                $display("FAIL ovf_fill cyc %0d: got %b exp %b", j, {tx, tx_busy, tx_empty, tx_full, overflow},
                         {e_tx, e_busy, e_empty, e_full, e_ovf});
            end
        end
        wr_en = 1'b0;
        checks++;
        if ({tx_full, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_flags: full/overflow got %b exp 11", {tx_full, overflow});
        end
        for (int j = 0; j < 17*11*DIV + 10; j++) begin
            tick();
            checks++;
            if ({tx, tx_busy, tx_empty, tx_full, overflow} !== {e_tx, e_busy, e_empty, e_full, e_ovf}) begin
                errors++;
                $display("FAIL ovf_drain cyc %0d: got %b exp %b", j, {tx, tx_busy, tx_empty, tx_full, overflow},
                         {e_tx, e_busy, e_empty, e_full, e_ovf});
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b exp 1", overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic f5a [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        wr_en = 1'b1;
        data_in = 8'hC3;
        tick();
        data_in = 8'h3C;
        tick();
        wr_en = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({tx, tx_busy, tx_empty, tx_full, overflow} !== 5'b10100) begin
            errors++;
            $display("FAIL midreset_state: got %b exp 10100", {tx, tx_busy, tx_empty, tx_full, overflow});
        end
        for (int j = 0; j < 100; j++) begin
            tick();
            checks++;
            if ({tx, tx_busy} !== 2'b10 || {tx, tx_busy, tx_empty} !== {e_tx, e_busy, e_empty}) begin
                errors++;
                $display("FAIL midreset_quiet cyc %0d: tx/busy got %b exp 10", j, {tx, tx_busy});
            end
        end
        wr_en = 1'b1;
        data_in = 8'h5A;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (tx !== f5a[i] || tx !== e_tx) begin
                    errors++;
                    $display("FAIL midreset_5a bit %0d: got %b exp %b", i, tx, f5a[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int n = $urandom_range(1, 5);
            int gap = $urandom_range(0, 60);
            for (int k = 0; k < n; k++) begin
                wr_en = ($urandom_range(0, 3) != 0);
                data_in = 8'($urandom);
                tick();
                checks++;
                if ({tx, tx_busy, tx_empty, tx_full, overflow} !== {e_tx, e_busy, e_empty, e_full, e_ovf}) begin
                    errors++;
                    $display("FAIL rand_wr b%0d k%0d: got %b exp %b", b, k, {tx, tx_busy, tx_empty, tx_full, overflow},
                             {e_tx, e_busy, e_empty, e_full, e_ovf});
                end
            end
            wr_en = 1'b0;
            for (int j = 0; j < gap; j++) begin
                tick();
                checks++;
                if ({tx, tx_busy, tx_empty, tx_full, overflow} !== {e_tx, e_busy, e_empty, e_full, e_ovf}) begin
                    errors++;
                    $display("FAIL rand_gap b%0d cyc %0d: got %b exp %b", b, j, {tx, tx_busy, tx_empty, tx_full, overflow},
                             {e_tx, e_busy, e_empty, e_full, e_ovf});
                end
            end
        end
        for (int j = 0; j < 31*11*DIV; j++) begin
            tick();
            checks++;
            if ({tx, tx_busy, tx_empty, tx_full, overflow} !== {e_tx, e_busy, e_empty, e_full, e_ovf}) begin
                errors++;
                $display("FAIL rand_drain cyc %0d: got %b exp %b", j, {tx, tx_busy, tx_empty, tx_full, overflow},
                         {e_tx, e_busy, e_empty, e_full, e_ovf});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_odd_parity();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
